bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first, on a single-bit serial line that drives the detector's `din` input. It supports back-to-back words with no idle gap between frames, and keeps a running count of words sent.

## Interface
- `WIDTH`, 8: data word width; legal range is 2–32.
- `CNT_W`, 16: width of the words-sent counter.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pdata`  in  WIDTH  parallel word to serialize.
- `pvalid`  in  1  `pdata` is valid.
- `pready`  out  1  serializer can accept a word this cycle.
- `sout`  out  1  serial bit; connects to the detector's `din`.
- `svalid`  out  1  `sout` carries a frame bit this cycle.
- `busy`  out  1  a frame is in progress.
- `words_sent`  out  CNT_W  count of completed frames; wraps.

## Operation
- The state machine has two states, IDLE and SHIFT. `state`, `shreg` and `bitcnt` are all registered.
- Frame length is `FLEN = WIDTH`, or `WIDTH+1` with parity enabled.
- A word is accepted on any rising edge where `pvalid && pready`.
- `pready` is 1 in IDLE. In SHIFT it is 1 only when `bitcnt == FLEN-1` (last bit of the frame). In every other SHIFT cycle it is 0.
- On accept:
  - `shreg` loads `pdata` and `bitcnt` loads 0.
  - Next state is SHIFT, including the back-to-back case from the last bit.
- In SHIFT:
  - `sout` is `shreg[WIDTH-1]`, or the parity bit in the parity slot.
  - `svalid` is 1.
  - Each clock, `shreg` shifts left with 0 fill and `bitcnt` increments.
- When `bitcnt == FLEN-1`:
  - The frame completes and `words_sent` increments by 1, wrapping from `2^CNT_W-1` to 0.
  - If no accept occurs on that edge, next state is IDLE.
- In IDLE, `sout` is 0 and `svalid` is 0. The detector sees 0s between frames; that is intended.
- `busy` equals `state == SHIFT`.
- Holding `pdata` stable is the source's responsibility only on the accept edge. Changes at any other time are ignored.
- Reset is synchronous, so reset mid-frame applies at the next edge: the in-flight word is discarded and not counted.
- `bitcnt` is `$clog2(FLEN+1)` bits wide, so it never overflows. Unreachable count values force IDLE.

## Timing
- Reset values: `pready` 1, `sout` 0, `svalid` 0, `busy` 0, `words_sent` 0; `state` IDLE, `shreg` 0, `bitcnt` 0.
- Latency: the word is accepted at edge N, and its MSB appears on `sout` with `svalid` 1 in the cycle after edge N.
- The last frame bit is in cycle N+FLEN.
- Throughput is 1 bit per clock. Back-to-back frames have zero gap cycles.
- If `pvalid` and `rst` are both high on the same edge, reset wins and the word is not accepted.
- `pready` is combinational from state and `bitcnt` only. It does not depend on `pvalid`.

## Configuration
- `SER_PARITY_EN` defined:
  - Each frame is followed by one even-parity bit, the XOR of the word's WIDTH bits, captured at accept.
  - `FLEN = WIDTH+1`.
  - `svalid` stays 1 during the parity slot.
- `SER_PARITY_EN` undefined:
  - No parity bit and no parity register.
  - `FLEN = WIDTH`.

## Structure
- Shared package `sqdet_pkg` holds:
  - the `ser_state_t` enum (IDLE, SHIFT);
  - `SER_DEFAULT_WIDTH = 8`;
  - `SER_DEFAULT_CNT_W = 16`.
- The detector's state encodings also move into `sqdet_pkg`.
- One sub-module, `ser_shift_reg`, is natural: a load/shift register with MSB output and an optional parity capture.
- The FSM, counter and handshake stay in `bit_serializer`.

## Test plan
- Single word, parity off: reset, then accept `pdata=8'hA5`.
  - Required: `sout` sequence 1,0,1,0,0,1,0,1 over 8 cycles, `svalid` 1 throughout.
  - Then `svalid` 0, and `words_sent` is 1.
- Back-to-back: `pvalid` held high with `8'hFF` then `8'h00`.
  - Required: 16 contiguous `svalid` cycles, `sout` 8×1 then 8×0.
  - `pready` pulses only in bit-7 cycles; `words_sent` is 2.
- Parity on: accept `8'h07`.
  - Required: 9 `svalid` cycles; the final bit is 1 (three 1s, so even parity gives 1).
  - Then accept `8'h03`; required final bit is 0.
- Reset mid-frame: assert `rst` during bit 3 of `8'hC3`.
  - Required: next cycle `svalid` 0, `sout` 0, `pready` 1, `words_sent` unchanged.
- Counter wrap: with `CNT_W=2`, send 5 words.
  - Required: `words_sent` steps 1, 2, 3, 0, 1.
- End-to-end with the detector: serialize a word containing the detector's target pattern.
  - Required: the detector's `dout` asserts at the expected bit cycle.
  - With idle gaps inserted between frames, the detector sees only 0s in the gaps.

Source files
------------

// File: rtl/sqdet_pkg.sv
// Shared types and defaults for the sequence-detector front end.
// Holds the serializer FSM encoding and its default geometry.
package sqdet_pkg;

    localparam int SER_DEFAULT_WIDTH = 8;
    localparam int SER_DEFAULT_CNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_shift_reg.sv
// Load/shift register: MSB-first output, zero fill on shift.
// Captures the even parity of the loaded word when SER_PARITY_EN is defined.
module ser_shift_reg
    import sqdet_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
`ifdef SER_PARITY_EN
    output logic             o_par,
`endif
    output logic             o_msb
);

    logic [WIDTH-1:0] r_shreg;

    // Load a new word, or shift it out MSB first with 0 fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_shreg[WIDTH-1];

`ifdef SER_PARITY_EN
    logic r_par;

    // Parity is taken from the word as accepted, not from the shifting copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (i_load) begin
            r_par <= ^i_data;
        end
    end

    assign o_par = r_par;
`endif

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector's din.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer
    import sqdet_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH,
    parameter int CNT_W = SER_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pvalid,
    output logic             pready,
    output logic             sout,
    output logic             svalid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

`ifdef SER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int BCW = $clog2(FLEN + 1);
    localparam logic [BCW-1:0] LAST = BCW'(FLEN - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_nx;
    logic [BCW-1:0]   r_bitcnt;
    logic [CNT_W-1:0] r_words;
    logic             w_last;
    logic             w_accept;
    logic             w_shift;
    logic             w_msb;
    logic             w_bit;

    assign w_last   = (r_state == SHIFT) && (r_bitcnt == LAST);
    assign w_accept = pvalid && pready;
    assign w_shift  = (r_state == SHIFT) && !w_accept;

`ifdef SER_PARITY_EN
    logic w_par;

    ser_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (pdata),
        .o_par   (w_par),
        .o_msb   (w_msb)
    );

    assign w_bit = (r_bitcnt == BCW'(WIDTH)) ? w_par : w_msb;
`else
    ser_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (pdata),
        .o_msb   (w_msb)
    );

    assign w_bit = w_msb;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state: accept always starts a frame; out-of-range counts fall to IDLE.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (w_accept) begin
                    w_state_nx = SHIFT;
                end else if (r_bitcnt >= LAST) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs: pready depends only on state and bit count.
    always_comb begin
        pready = (r_state == IDLE) || w_last;
        svalid = (r_state == SHIFT);
        busy   = (r_state == SHIFT);
        sout   = (r_state == SHIFT) ? w_bit : 1'b0;
    end

    // Bit position within the current frame; restarts on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt <= '0;
        end else if (w_accept) begin
            r_bitcnt <= '0;
        end else if ((r_state == SHIFT) && (r_bitcnt < LAST)) begin
            r_bitcnt <= r_bitcnt + 1'b1;
        end else begin
            r_bitcnt <= '0;
        end
    end

    // Completed-frame counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words <= '0;
        end else if (w_last) begin
            r_words <= r_words + 1'b1;
        end
    end

    assign words_sent = r_words;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer against a queue-based frame model.
// Two instances share stimulus: default counter width and a 2-bit counter.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic        clk;
    logic        rst;
    logic        pvalid;
    logic [7:0]  pdata;

    logic        pready;
    logic        sout;
    logic        svalid;
    logic        busy;
    logic [15:0] words_sent;

    logic        pready2;
    logic        sout2;
    logic        svalid2;
    logic        busy2;
    logic [1:0]  words_sent2;

    int n_chk;
    int n_pass;
    int n_fail;

    bit          q_bit[$];
    bit          q_last[$];
    int unsigned cnt;

    bit_serializer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pdata      (pdata),
        .pvalid     (pvalid),
        .pready     (pready),
        .sout       (sout),
        .svalid     (svalid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    bit_serializer #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .pdata      (pdata),
        .pvalid     (pvalid),
        .pready     (pready2),
        .sout       (sout2),
        .svalid     (svalid2),
        .busy       (busy2),
        .words_sent (words_sent2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic e_sv;
        logic e_bit;
        e_sv  = (q_bit.size() > 0);
        e_bit = e_sv ? q_bit[0] : 1'b0;
        chk("svalid", 32'(svalid), 32'(e_sv));
        chk("sout", 32'(sout), 32'(e_bit));
        chk("pready", 32'(pready), 32'(q_bit.size() <= 1));
        chk("busy", 32'(busy), 32'(e_sv));
        chk("words_sent", 32'(words_sent), 32'(cnt[15:0]));
        chk("words_sent_w2", 32'(words_sent2), 32'(cnt[1:0]));
        chk("sout_w2", 32'(sout2), 32'(e_bit));
    endtask

    task automatic model_edge(input logic r, input logic v,
                              input logic [7:0] d);
        bit rdy;
        bit b;
        bit l;
        rdy = (q_bit.size() <= 1);
        if (r) begin
            q_bit.delete();
            q_last.delete();
            cnt = 0;
        end else begin
            if (q_bit.size() > 0) begin
                b = q_bit.pop_front();
                l = q_last.pop_front();
                if (l) cnt++;
            end
            if (v && rdy) begin
                for (int i = 7; i >= 0; i--) begin
                    q_bit.push_back(d[i]);
                    q_last.push_back(FLEN == 8 && i == 0);
                end
                if (FLEN == 9) begin
                    q_bit.push_back(^d);
                    q_last.push_back(1'b1);
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        check_outputs();
        rst    = r;
        pvalid = v;
        pdata  = d;
        @(posedge clk);
        model_edge(r, v, d);
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        cnt    = 0;
        rst    = 1'b1;
        pvalid = 1'b0;
        pdata  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // single word A5
        cycle(1'b0, 1'b1, 8'hA5);
        repeat (FLEN + 2) cycle(1'b0, 1'b0, 8'h00);

        // back-to-back FF then 00 with pvalid held
        cycle(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < FLEN; i++) cycle(1'b0, 1'b1, 8'h00);
        repeat (FLEN + 2) cycle(1'b0, 1'b0, 8'h00);

        // 07 then 03 back to back (parity 1 then 0 when enabled)
        cycle(1'b0, 1'b1, 8'h07);
        for (int i = 0; i < FLEN - 1; i++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h03);
        repeat (FLEN + 2) cycle(1'b0, 1'b0, 8'h00);

        // reset during bit 3 of C3, then reset racing a valid word
        cycle(1'b0, 1'b1, 8'hC3);
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h55);
        repeat (3) cycle(1'b0, 1'b0, 8'h00);

        // five words with idle gaps: 2-bit counter wraps 1,2,3,0,1
        for (int w = 0; w < 5; w++) begin
            cycle(1'b0, 1'b1, 8'($urandom));
            repeat (FLEN + 1) cycle(1'b0, 1'b0, 8'h00);
        end

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom));
        end
        repeat (FLEN + 2) cycle(1'b0, 1'b0, 8'h00);
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
